id_ex_pipe_reg: RTL and testbench

Parametrised ID/EX pipeline stage register for the pipelined MIPS core, sitting between the decode stage and the ALU/EX stage. It carries the packed control bundle (WREG, M2REG, WMEM, ALUC, ALUIMM, SHIFT), both source operands, the extended immediate and the destination register address. Unlike a plain edge-triggered stage latch, it adds a valid/ready handshake for hazard stalls, a synchronous flush for branch/jump squash, bubble insertion with control zeroing, and an optional two-entry skid buffer that breaks the combinational ready path.

---
 rtl/id_ex_pipe_reg.sv | 151 +++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline stage register with valid/ready handshake.
//
// Carries the decoded control bundle {WREG, M2REG, WMEM, ALUC[2:0], ALUIMM, SHIFT},
// both source operands, the extended immediate and the destination register
// from decode into EX. The stage supports hazard stalls through valid/ready,
// a synchronous flush for branch/jump squash, and control zeroing on bubbles.
//
// Build option:
//   PIPE_SKID_EN  defined   -> two-entry skid buffer; in_ready is a flop output,
//                              so there is no combinational path out_ready->in_ready.
//                 undefined -> single entry; in_ready = !out_valid || out_ready.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   flush           squash held and incoming beats (next state empty)
//   in_valid/ready  decode-side handshake
//   in_ctrl, in_src_a, in_src_b, in_imm, in_rd    incoming beat
//   out_valid/ready EX-side handshake
//   out_ctrl        control bundle, zero whenever out_valid is low
//   out_src_a, out_src_b, out_imm, out_rd         registered payload
//   occupancy       number of held beats (0..2)
module id_ex_pipe_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_src_a,
  input  logic [DATA_W-1:0] in_src_b,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [ADDR_W-1:0] in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_src_a,
  output logic [DATA_W-1:0] out_src_b,
  output logic [DATA_W-1:0] out_imm,
  output logic [ADDR_W-1:0] out_rd,
  output logic [1:0]        occupancy
);

  localparam int unsigned BeatW = CTRL_W + 3 * DATA_W + ADDR_W;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StFull  = 2'd1,
    StSkid  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [BeatW-1:0]   out_beat_q, out_beat_d;
  logic [BeatW-1:0]   in_beat;
  logic [CTRL_W-1:0]  held_ctrl;
  logic               accept;
  logic               deliver;

  assign in_beat   = {in_ctrl, in_src_a, in_src_b, in_imm, in_rd};
  assign out_valid = (state_q != StEmpty);
  assign accept    = in_valid && in_ready;
  assign deliver   = out_valid && out_ready;

`ifdef PIPE_SKID_EN
  logic [BeatW-1:0] skid_beat_q, skid_beat_d;
  logic             in_ready_q, in_ready_d;

  assign in_ready   = in_ready_q;
  assign occupancy  = (state_q == StSkid) ? 2'd2 : (state_q == StFull) ? 2'd1 : 2'd0;
`else
  assign in_ready   = !out_valid || out_ready;
  assign occupancy  = {1'b0, (state_q == StFull)};
`endif

  always_comb begin
    state_d    = state_q;
    out_beat_d = out_beat_q;
`ifdef PIPE_SKID_EN
    skid_beat_d = skid_beat_q;
`endif
    if (flush) begin
      // Squash wins: any beat offered this cycle is dropped, a deliver still counts.
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d    = StFull;
            out_beat_d = in_beat;
          end
        end
        StFull: begin
          if (deliver) begin
            if (accept) begin
              out_beat_d = in_beat;
            end else begin
              state_d = StEmpty;
            end
          end else if (accept) begin
`ifdef PIPE_SKID_EN
            state_d     = StSkid;
            skid_beat_d = in_beat;
`endif
          end
        end
`ifdef PIPE_SKID_EN
        StSkid: begin
          if (deliver) begin
            state_d    = StFull;
            out_beat_d = skid_beat_q;
          end
        end
`endif
        default: state_d = StEmpty;
      endcase
    end
  end

`ifdef PIPE_SKID_EN
  // Registered ready: derived from the next state so it never sees out_ready combinationally.
  always_comb begin
    in_ready_d = (state_d != StSkid);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StEmpty;
      out_beat_q <= '0;
`ifdef PIPE_SKID_EN
      skid_beat_q <= '0;
      in_ready_q  <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      out_beat_q <= out_beat_d;
`ifdef PIPE_SKID_EN
      skid_beat_q <= skid_beat_d;
      in_ready_q  <= in_ready_d;
`endif
    end
  end

  assign {held_ctrl, out_src_a, out_src_b, out_imm, out_rd} = out_beat_q;
  // Bubbles carry no control so EX never sees a spurious WREG/WMEM.
  assign out_ctrl = out_valid ? held_ctrl : '0;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
module tb_id_ex_pipe_reg;

  typedef struct packed {
    logic [7:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rd;
  } beat_t;

`ifdef PIPE_SKID_EN
  localparam bit Skid = 1'b1;
`else
  localparam bit Skid = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_ctrl;
  logic [31:0] in_src_a, in_src_b, in_imm;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_ctrl;
  logic [31:0] out_src_a, out_src_b, out_imm;
  logic [4:0]  out_rd;
  logic [1:0]  occupancy;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  beat_t q[$];

  id_ex_pipe_reg #(.DATA_W(32), .CTRL_W(8), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_src_a(in_src_a), .in_src_b(in_src_b),
    .in_imm(in_imm), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_src_a(out_src_a), .out_src_b(out_src_b),
    .out_imm(out_imm), .out_rd(out_rd), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Ready as the rules define it: skid build accepts while fewer than two are held;
  // single build accepts when empty or when the held beat leaves this cycle.
  function automatic bit model_ready();
    if (Skid) return q.size() < 2;
    return (q.size() == 0) || out_ready;
  endfunction

  // Reference model: a FIFO of beats with capacity 1 or 2.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
    end else begin
      bit acc, del;
      beat_t nb;
      acc = in_valid && model_ready();
      del = (q.size() > 0) && out_ready;
      nb  = '{ctrl: in_ctrl, a: in_src_a, b: in_src_b, imm: in_imm, rd: in_rd};
      if (flush) begin
        q.delete();
      end else begin
        if (del) void'(q.pop_front());
        if (acc) q.push_back(nb);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("occupancy", occupancy, q.size());
      check("out_valid", out_valid, q.size() > 0);
      check("in_ready", in_ready, model_ready());
      if (q.size() > 0) begin
        check("out_ctrl", out_ctrl, q[0].ctrl);
        check("out_src_a", out_src_a, q[0].a);
        check("out_src_b", out_src_b, q[0].b);
        check("out_imm", out_imm, q[0].imm);
        check("out_rd", out_rd, q[0].rd);
      end else begin
        check("bubble_ctrl", out_ctrl, 8'h00);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_in(input bit v, input logic [7:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
    in_valid = v;
    in_ctrl  = c;
    in_src_a = a;
    in_src_b = b;
    in_imm   = a ^ b;
    in_rd    = rd;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    set_in(1'b0, 8'h00, 32'h0, 32'h0, 5'd0);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_occupancy", occupancy, 2'd0);
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);

    // Streaming: one beat per cycle, each visible the cycle after accept.
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      set_in(1'b1, 8'h80, 32'(k * 3), 32'(k * 5), 5'(k));
      tick();
      check("stream_rd", out_rd, 64'(k));
      check("stream_valid", out_valid, 1'b1);
    end
    set_in(1'b0, 8'h00, 32'h0, 32'h0, 5'd0);
    tick();

    // Stall.
    out_ready = 1'b0;
    set_in(1'b1, 8'h84, 32'hA, 32'h1234, 5'd10);
    tick();
    if (Skid) begin
      set_in(1'b1, 8'h88, 32'hB, 32'h5678, 5'd11);
      tick();
      check("stall_occ2", occupancy, 2'd2);
      check("stall_ready0", in_ready, 1'b0);
      check("stall_head", out_rd, 5'd10);
      set_in(1'b0, 8'h00, 32'h0, 32'h0, 5'd0);
      out_ready = 1'b1;
      tick();
      check("skid_second", out_rd, 5'd11);
      check("skid_occ1", occupancy, 2'd1);
      tick();
      check("skid_drained", out_valid, 1'b0);
    end else begin
      set_in(1'b1, 8'h88, 32'hB, 32'h5678, 5'd11);
      #1;
      check("stall_ready0", in_ready, 1'b0);
      tick();
      check("stall_hold_b", out_src_b, 32'h1234);
      check("stall_hold_rd", out_rd, 5'd10);
      set_in(1'b0, 8'h00, 32'h0, 32'h0, 5'd0);
      out_ready = 1'b1;
      tick();
      check("stall_drained", out_valid, 1'b0);
    end

    // Flush while holding as much as the build allows, with a beat on the input.
    out_ready = 1'b0;
    set_in(1'b1, 8'hA0, 32'h1, 32'h2, 5'd12);
    tick();
    if (Skid) begin
      set_in(1'b1, 8'hA4, 32'h3, 32'h4, 5'd13);
      tick();
    end
    flush = 1'b1;
    set_in(1'b1, 8'hFF, 32'h5, 32'h6, 5'd20);
    tick();
    flush = 1'b0;
    set_in(1'b0, 8'h00, 32'h0, 32'h0, 5'd0);
    check("flush_valid", out_valid, 1'b0);
    check("flush_ctrl", out_ctrl, 8'h00);
    check("flush_occ", occupancy, 2'd0);
    out_ready = 1'b1;
    tick();
    tick();
    check("flush_no_ghost", out_valid, 1'b0);

    // Bubble control zeroing.
    set_in(1'b1, 8'hE5, 32'h7, 32'h8, 5'd21);
    tick();
    check("bubble_pre_ctrl", out_ctrl, 8'hE5);
    set_in(1'b0, 8'h00, 32'h0, 32'h0, 5'd0);
    tick();
    check("bubble_ctrl0", out_ctrl, 8'h00);
    check("bubble_valid0", out_valid, 1'b0);

    // Asynchronous reset while full.
    out_ready = 1'b0;
    set_in(1'b1, 8'hC0, 32'hDEADBEEF, 32'h9, 5'd22);
    tick();
    set_in(1'b0, 8'h00, 32'h0, 32'h0, 5'd0);
    check("pre_rst_a", out_src_a, 32'hDEADBEEF);
    chk_en = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_ctrl", out_ctrl, 8'h00);
    check("arst_src_a", out_src_a, 32'h0);
    check("arst_rd", out_rd, 5'd0);
    check("arst_occ", occupancy, 2'd0);
    tick();
    rst = 1'b0;
    chk_en = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom_range(0, 3) != 0), 8'($urandom), $urandom, $urandom, 5'($urandom));
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      tick();
    end
    flush = 1'b0;
    set_in(1'b0, 8'h00, 32'h0, 32'h0, 5'd0);
    out_ready = 1'b1;
    tick();
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
